// File: rtl/line_raster_pkg.sv
// Screen render parameters and the shared types for the line rasteriser.
package line_raster_pkg;

  localparam int SCX = 10;
  localparam int SCY = 9;

  // Error terms need two bits beyond the widest coordinate so 2*err never overflows.
  function automatic int lineErrW(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

  localparam int LINE_ERRW = lineErrW(SCX, SCY);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW
  } line_state_t;

endpackage

// File: rtl/line_raster_bres.sv
// One Bresenham step: from the current pixel and error term, produce the next pixel and error.
module bres_step #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int W  = 12
) (
  input  logic [XW-1:0]       curX_i,
  input  logic [YW-1:0]       curY_i,
  input  logic signed [W-1:0] err_i,
  input  logic signed [W-1:0] dx_i,
  input  logic signed [W-1:0] dy_i,
  input  logic                sxNeg_i,
  input  logic                syNeg_i,
  output logic [XW-1:0]       nextX_o,
  output logic [YW-1:0]       nextY_o,
  output logic signed [W-1:0] nextErr_o
);

  localparam logic [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] ONE_Y = {{(YW-1){1'b0}}, 1'b1};

  logic signed [W:0] e2;
  logic signed [W:0] dxExt;
  logic signed [W:0] dyExt;
  logic              stepX;
  logic              stepY;

  // Both decisions use the same e2, taken before either error update is applied.
  always_comb begin
    e2     = {err_i, 1'b0};
    dxExt  = {dx_i[W-1], dx_i};
    dyExt  = {dy_i[W-1], dy_i};
    stepX  = (e2 >= dyExt);
    stepY  = (e2 <= dxExt);

    nextErr_o = err_i;
    if (stepX) nextErr_o = nextErr_o + dy_i;
    if (stepY) nextErr_o = nextErr_o + dx_i;

    nextX_o = curX_i;
    if (stepX) nextX_o = sxNeg_i ? (curX_i - ONE_X) : (curX_i + ONE_X);

    nextY_o = curY_i;
    if (stepY) nextY_o = syNeg_i ? (curY_i - ONE_Y) : (curY_i + ONE_Y);
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: accepts one segment, streams its pixels one per cycle under backpressure.
module line_raster
  import line_raster_pkg::*;
#(
  parameter int XW = SCX,
  parameter int YW = SCY
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pixx,
  output logic [YW-1:0] pixy,
  output logic          pix_last,
  output logic          busy
);

  localparam int W = lineErrW(XW, YW);

  line_state_t         state_q;
  logic [XW-1:0]       curX_q;
  logic [YW-1:0]       curY_q;
  logic [XW-1:0]       endX_q;
  logic [YW-1:0]       endY_q;
  logic signed [W-1:0] dx_q;
  logic signed [W-1:0] dy_q;
  logic signed [W-1:0] err_q;
  logic                sxNeg_q;
  logic                syNeg_q;
  logic                inReady_q;
  logic                pixValid_q;
  logic                pixLast_q;
  logic                busy_q;

  logic [XW-1:0]       diffX_d;
  logic [YW-1:0]       diffY_d;
  logic signed [W-1:0] dxMag_d;
  logic signed [W-1:0] dyMag_d;
  logic [XW-1:0]       stepX_d;
  logic [YW-1:0]       stepY_d;
  logic signed [W-1:0] stepErr_d;

  // Segment magnitudes, computed from the latched endpoints during SETUP.
  always_comb begin
    diffX_d = (endX_q >= curX_q) ? (endX_q - curX_q) : (curX_q - endX_q);
    diffY_d = (endY_q >= curY_q) ? (endY_q - curY_q) : (curY_q - endY_q);
    dxMag_d = {{(W-XW){1'b0}}, diffX_d};
    dyMag_d = {{(W-YW){1'b0}}, diffY_d};
  end

  bres_step #(
    .XW(XW),
    .YW(YW),
    .W (W)
  ) uStep (
    .curX_i   (curX_q),
    .curY_i   (curY_q),
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sxNeg_i  (sxNeg_q),
    .syNeg_i  (syNeg_q),
    .nextX_o  (stepX_d),
    .nextY_o  (stepY_d),
    .nextErr_o(stepErr_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      curX_q     <= '0;
      curY_q     <= '0;
      endX_q     <= '0;
      endY_q     <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sxNeg_q    <= 1'b0;
      syNeg_q    <= 1'b0;
      inReady_q  <= 1'b1;
      pixValid_q <= 1'b0;
      pixLast_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            curX_q    <= x0;
            curY_q    <= y0;
            endX_q    <= x1;
            endY_q    <= y1;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          dx_q       <= dxMag_d;
          dy_q       <= -dyMag_d;
          err_q      <= dxMag_d - dyMag_d;
          sxNeg_q    <= (endX_q < curX_q);
          syNeg_q    <= (endY_q < curY_q);
          pixValid_q <= 1'b1;
          pixLast_q  <= (curX_q == endX_q) && (curY_q == endY_q);
          state_q    <= DRAW;
        end
        DRAW: begin
          // Everything holds while the framebuffer writer stalls.
          if (pix_ready) begin
            if (pixLast_q) begin
              pixValid_q <= 1'b0;
              pixLast_q  <= 1'b0;
              inReady_q  <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              curX_q    <= stepX_d;
              curY_q    <= stepY_d;
              err_q     <= stepErr_d;
              pixLast_q <= (stepX_d == endX_q) && (stepY_d == endY_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign pix_valid = pixValid_q;
  assign pix_last  = pixLast_q;
  assign pixx      = curX_q;
  assign pixy      = curY_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster: hand-computed pixel sequences, stalls, and reset mid-line.
module tb_line_raster;
  import line_raster_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pixx;
  logic [8:0] pixy;
  logic       pix_last;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int expX[$];
  int expY[$];

  always #5 clk = ~clk;

  line_raster #(.XW(10), .YW(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pixx     (pixx),
    .pixy     (pixy),
    .pix_last (pix_last),
    .busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pushPix(input int px, input int py);
    expX.push_back(px);
    expY.push_back(py);
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1,
                               input int stallIdx, input int abortIdx, input bit noise);
    int n;
    n = expX.size();
    checkOutput("in_ready idle", in_ready, 1);
    x0 = ax0[9:0]; y0 = ay0[8:0]; x1 = ax1[9:0]; y1 = ay1[8:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("setup pix_valid", pix_valid, 0);
    checkOutput("setup busy", busy, 1);
    checkOutput("setup in_ready", in_ready, 0);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == abortIdx) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort pix_valid", pix_valid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort pixx", pixx, 0);
        checkOutput("abort in_ready", in_ready, 1);
        @(negedge clk);
        checkOutput("abort stays idle", pix_valid, 0);
        return;
      end
      if (noise) begin
        in_valid = (i != n - 1);
        x0 = 10'd9; y0 = 9'd9; x1 = 10'd1; y1 = 9'd1;
      end
      if (i == stallIdx) begin
        pix_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall pix_valid", pix_valid, 1);
          checkOutput("stall pixx", pixx, expX[i]);
          checkOutput("stall pixy", pixy, expY[i]);
          checkOutput("stall pix_last", pix_last, 0);
        end
        pix_ready = 1'b1;
      end
      checkOutput("pix_valid", pix_valid, 1);
      checkOutput("pixx", pixx, expX[i]);
      checkOutput("pixy", pixy, expY[i]);
      checkOutput("pix_last", pix_last, (i == n - 1) ? 1 : 0);
      checkOutput("busy draw", busy, 1);
      checkOutput("in_ready draw", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("done pix_valid", pix_valid, 0);
    checkOutput("done in_ready", in_ready, 1);
    checkOutput("done busy", busy, 0);
    checkOutput("done pix_last", pix_last, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset pix_valid", pix_valid, 0);
    checkOutput("reset pix_last", pix_last, 0);
    checkOutput("reset pixx", pixx, 0);
    checkOutput("reset pixy", pixy, 0);
    checkOutput("reset busy", busy, 0);

    $display("[TB] horizontal with ignored requests");
    expX.delete(); expY.delete();
    pushPix(0, 0); pushPix(1, 0); pushPix(2, 0); pushPix(3, 0);
    applyStimulus(0, 0, 3, 0, -1, -1, 1'b1);

    $display("[TB] steep");
    expX.delete(); expY.delete();
    pushPix(0, 0); pushPix(0, 1); pushPix(1, 2); pushPix(1, 3);
    applyStimulus(0, 0, 1, 3, -1, -1, 1'b0);

    $display("[TB] steep reversed");
    expX.delete(); expY.delete();
    pushPix(1, 3); pushPix(1, 2); pushPix(0, 1); pushPix(0, 0);
    applyStimulus(1, 3, 0, 0, -1, -1, 1'b0);

    $display("[TB] diagonal negative");
    expX.delete(); expY.delete();
    pushPix(5, 5); pushPix(4, 4); pushPix(3, 3); pushPix(2, 2);
    applyStimulus(5, 5, 2, 2, -1, -1, 1'b0);

    $display("[TB] shallow");
    expX.delete(); expY.delete();
    pushPix(0, 0); pushPix(1, 0); pushPix(2, 1); pushPix(3, 1);
    applyStimulus(0, 0, 3, 1, -1, -1, 1'b0);

    $display("[TB] single point");
    expX.delete(); expY.delete();
    pushPix(7, 9);
    applyStimulus(7, 9, 7, 9, -1, -1, 1'b0);

    $display("[TB] screen corner");
    expX.delete(); expY.delete();
    pushPix(1023, 511); pushPix(1022, 511); pushPix(1021, 511);
    applyStimulus(1023, 511, 1021, 511, -1, -1, 1'b0);

    $display("[TB] backpressure");
    expX.delete(); expY.delete();
    pushPix(0, 0); pushPix(1, 0); pushPix(2, 0); pushPix(3, 0);
    applyStimulus(0, 0, 3, 0, 1, -1, 1'b0);

    $display("[TB] reset mid-line");
    expX.delete(); expY.delete();
    for (int i = 0; i <= 10; i++) pushPix(i, 0);
    applyStimulus(0, 0, 10, 0, -1, 3, 1'b0);

    $display("[TB] after reset");
    expX.delete(); expY.delete();
    pushPix(2, 2); pushPix(2, 3); pushPix(2, 4);
    applyStimulus(2, 2, 2, 4, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
